// File: rtl/mac_10g_chk_pkg.sv
// Shared types and constants for the 10G receive frame checker.
// Status codes are part of the scoreboard/statistics record format.
package mac_10g_chk_pkg;

    import mac_10g_param_pkg::*;

    typedef enum logic [2:0] {
        GOOD     = 3'd0,
        MAC_ERR  = 3'd1,
        RUNT     = 3'd2,
        OVERSIZE = 3'd3,
        FRAMING  = 3'd4
    } stat_code_e;

    localparam int BYTES_PER_BEAT = MAC_DWIDTH / 8;

endpackage

// File: rtl/parameter.sv
// Shared 10G MAC bus geometry.
// Every block on the MAC bus takes its data and empty widths from here.
package mac_10g_param_pkg;

    localparam int MAC_DWIDTH    = 64;
    localparam int MAC_MOD_WIDTH = 3;

endpackage

// File: rtl/mac_10g_cnt.sv
// Generic statistics counter: increment, synchronous clear, optional saturation.
// A clear in the same cycle as an increment leaves the counter at zero.
module mac_10g_cnt #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_hold;

    assign w_hold = SATURATE && (&r_cnt);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_hold) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_10g_rx_chk.sv
// 10G MAC receive frame checker: framing check, byte length, classification,
// one registered status record per frame plus good/bad/orphan statistics.
module mac_10g_rx_chk
    import mac_10g_chk_pkg::*;
#(
    parameter int MAC_DWIDTH    = mac_10g_param_pkg::MAC_DWIDTH,
    parameter int MAC_MOD_WIDTH = mac_10g_param_pkg::MAC_MOD_WIDTH,
    parameter int MIN_LEN       = 64,
    parameter int MAX_LEN       = 1518,
    parameter int LEN_WIDTH     = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clk_en,
    input  logic                     i_dv,
    input  logic                     i_data_en,
    input  logic [MAC_DWIDTH-1:0]    i_data,
    input  logic                     i_sop,
    input  logic                     i_eop,
    input  logic [MAC_MOD_WIDTH-1:0] i_empty,
    input  logic                     i_error,
    input  logic                     i_clr_cnt,
    output logic                     o_stat_vld,
    output logic [LEN_WIDTH-1:0]     o_stat_len,
    output logic [2:0]               o_stat_code,
    output logic [CNT_WIDTH-1:0]     o_good_cnt,
    output logic [CNT_WIDTH-1:0]     o_bad_cnt,
    output logic [15:0]              o_orphan_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;

    localparam logic [LEN_WIDTH-1:0] BPB   = LEN_WIDTH'(MAC_DWIDTH / 8);
    localparam logic [31:0]          MIN_L = 32'(MIN_LEN);
    localparam logic [31:0]          MAX_L = 32'(MAX_LEN);

    // Length never wraps: a carry out pins the sum at all-ones.
    function automatic logic [LEN_WIDTH-1:0] sat_add(
        input logic [LEN_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0] b
    );
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_WIDTH] ? '1 : s[LEN_WIDTH-1:0];
    endfunction

    logic [0:0]           r_state;
    logic [LEN_WIDTH-1:0] r_acc;
    logic                 r_stat_vld;
    logic [LEN_WIDTH-1:0] r_stat_len;
    stat_code_e           r_stat_code;

    logic [0:0]           w_state_nxt;
    logic [LEN_WIDTH-1:0] w_acc_nxt;
    logic                 w_accept;
    logic [LEN_WIDTH-1:0] w_tail;
    logic [LEN_WIDTH-1:0] w_beat_bytes;
    logic [LEN_WIDTH-1:0] w_sum;
    logic                 w_rep;
    logic [LEN_WIDTH-1:0] w_rep_len;
    logic                 w_framing;
    logic                 w_err;
    logic                 w_orphan;
    stat_code_e           w_code;
    logic                 w_unused_data;

    assign w_unused_data = ^i_data;

    assign w_accept     = i_clk_en && i_data_en;
    assign w_tail       = BPB - LEN_WIDTH'(i_empty);
    assign w_beat_bytes = i_eop ? w_tail : BPB;
    assign w_sum        = sat_add(r_acc, w_beat_bytes);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rep       = 1'b0;
        w_rep_len   = r_acc;
        w_framing   = 1'b0;
        w_err       = 1'b0;
        w_orphan    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!i_sop) begin
                        w_orphan = 1'b1;
                    end else if (i_eop) begin
                        w_rep     = 1'b1;
                        w_rep_len = w_tail;
                        w_err     = i_error;
                        w_acc_nxt = '0;
                    end else begin
                        w_acc_nxt   = BPB;
                        w_state_nxt = S_FRAME;
                    end
                end
            end
            S_FRAME: begin
                if (i_clk_en && (!i_dv || (i_data_en && i_sop))) begin
                    // Abort: report what was gathered; a stray sop beat is dropped.
                    w_rep       = 1'b1;
                    w_framing   = 1'b1;
                    w_rep_len   = r_acc;
                    w_orphan    = w_accept && i_sop;
                    w_acc_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    if (i_eop) begin
                        w_rep       = 1'b1;
                        w_rep_len   = w_sum;
                        w_err       = i_error;
                        w_acc_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_acc_nxt = w_sum;
                    end
                end
            end
            default: begin
                w_acc_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_code = GOOD;
        if (w_framing) begin
            w_code = FRAMING;
        end else if (w_err) begin
            w_code = MAC_ERR;
        end else if (32'(w_rep_len) < MIN_L) begin
            w_code = RUNT;
        end else if (32'(w_rep_len) > MAX_L) begin
            w_code = OVERSIZE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_stat_vld  <= 1'b0;
            r_stat_len  <= '0;
            r_stat_code <= GOOD;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_stat_vld <= w_rep;
            if (w_rep) begin
                r_stat_len  <= w_rep_len;
                r_stat_code <= w_code;
            end
        end
    end

    assign o_stat_vld  = r_stat_vld;
    assign o_stat_len  = r_stat_len;
    assign o_stat_code = r_stat_code;

    mac_10g_cnt #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_good_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr_cnt),
        .i_inc   (w_rep && (w_code == GOOD)),
        .o_cnt   (o_good_cnt)
    );

    mac_10g_cnt #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_bad_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr_cnt),
        .i_inc   (w_rep && (w_code != GOOD)),
        .o_cnt   (o_bad_cnt)
    );

    mac_10g_cnt #(
        .WIDTH    (16),
        .SATURATE (1'b1)
    ) u_orphan_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr_cnt),
        .i_inc   (w_orphan),
        .o_cnt   (o_orphan_cnt)
    );

endmodule

// File: tb/tb_mac_10g_rx_chk.sv
// Bench for mac_10g_rx_chk: directed and random frames checked against
// a frame-level length/classification model and a status scoreboard.
module tb_mac_10g_rx_chk;

    import mac_10g_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en, dv, data_en, sop, eop, error, clr_cnt;
    logic [63:0] data;
    logic [2:0]  empty;
    logic        stat_vld;
    logic [15:0] stat_len;
    logic [2:0]  stat_code;
    logic [31:0] good_cnt, bad_cnt;
    logic [15:0] orphan_cnt;

    always #5 clk = ~clk;

    mac_10g_rx_chk dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clk_en     (clk_en),
        .i_dv         (dv),
        .i_data_en    (data_en),
        .i_data       (data),
        .i_sop        (sop),
        .i_eop        (eop),
        .i_empty      (empty),
        .i_error      (error),
        .i_clr_cnt    (clr_cnt),
        .o_stat_vld   (stat_vld),
        .o_stat_len   (stat_len),
        .o_stat_code  (stat_code),
        .o_good_cnt   (good_cnt),
        .o_bad_cnt    (bad_cnt),
        .o_orphan_cnt (orphan_cnt)
    );

    typedef struct {
        int len;
        int code;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_good   = 0;
    int   m_bad    = 0;
    int   m_orph   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected record and counter effect of one reported frame.
    task automatic expect_frame(input int len, input bit framing, input bit err);
        exp_t e;
        e.len = (len > 65535) ? 65535 : len;
        if (framing)         e.code = 4;
        else if (err)        e.code = 1;
        else if (e.len < 64) e.code = 2;
        else if (e.len > 1518) e.code = 3;
        else                 e.code = 0;
        exp_q.push_back(e);
        if (e.code == 0) m_good++;
        else             m_bad++;
    endtask

    always @(negedge clk) begin
        if (stat_vld === 1'b1) begin
            chk("stat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stat_len", 32'(stat_len), e.len);
                chk("stat_code", 32'(stat_code), e.code);
            end
        end
    end

    task automatic put(input bit ce, input bit v, input bit de, input bit s,
                       input bit e, input logic [2:0] emp, input bit err);
        clk_en  = ce;
        dv      = v;
        data_en = de;
        sop     = s;
        eop     = e;
        empty   = emp;
        error   = err;
        data    = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic garbage_ce_low();
        put(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom));
    endtask

    task automatic frame(input int n, input int emp, input bit err,
                         input bit toggle, input int gap_pct, input bit clr_eop);
        expect_frame(8 * (n - 1) + 8 - emp, 1'b0, err);
        if (clr_eop) begin
            m_good = 0;
            m_bad  = 0;
            m_orph = 0;
        end
        for (int i = 0; i < n; i++) begin
            bit last;
            last = (i == n - 1);
            if (toggle) garbage_ce_low();
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'($urandom), 1'b0);
            clr_cnt = clr_eop && last;
            put(1'b1, 1'b1, 1'b1, i == 0, last,
                last ? 3'(emp) : 3'($urandom),
                last ? err : 1'($urandom));
            clr_cnt = 1'b0;
        end
    endtask

    task automatic abort_sop(input int k);
        expect_frame(8 * k, 1'b1, 1'b0);
        m_orph++;
        for (int i = 0; i < k; i++)
            put(1'b1, 1'b1, 1'b1, i == 0, 1'b0, 3'd0, 1'b0);
        put(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic abort_dv(input int k);
        expect_frame(8 * k, 1'b1, 1'b0);
        for (int i = 0; i < k; i++)
            put(1'b1, 1'b1, 1'b1, i == 0, 1'b0, 3'd0, 1'b0);
        put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic orphans(input int k);
        for (int i = 0; i < k; i++) begin
            m_orph++;
            put(1'b1, 1'($urandom), 1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'b0);
        end
    endtask

    task automatic chk_cnt(input string tag);
        idle(2);
        chk({tag, "_good"}, good_cnt, m_good);
        chk({tag, "_bad"}, bad_cnt, m_bad);
        chk({tag, "_orphan"}, 32'(orphan_cnt), m_orph);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_cnt = 1'b0;
        clk_en  = 1'b0;
        dv      = 1'b0;
        data_en = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        empty   = '0;
        error   = 1'b0;
        data    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_vld", 32'(stat_vld), 0);
        chk("rst_len", 32'(stat_len), 0);
        chk("rst_code", 32'(stat_code), 0);
        chk_cnt("rst");

        frame(8, 0, 1'b0, 1'b0, 0, 1'b0);
        chk_cnt("good64");
        frame(1, 3, 1'b0, 1'b0, 0, 1'b0);
        chk_cnt("runt5");
        frame(24, 2, 1'b1, 1'b0, 0, 1'b0);
        chk_cnt("macerr190");
        abort_sop(3);
        chk_cnt("abort_sop");
        frame(191, 0, 1'b0, 1'b0, 0, 1'b0);
        chk_cnt("over1528");
        frame(191, 0, 1'b0, 1'b1, 0, 1'b0);
        chk_cnt("over1528_ce");

        frame(8, 1, 1'b0, 1'b0, 0, 1'b0);
        frame(190, 2, 1'b0, 1'b0, 0, 1'b0);
        frame(190, 1, 1'b0, 1'b0, 0, 1'b0);
        abort_dv(5);
        chk_cnt("bounds");

        for (int i = 0; i < 12; i++) begin
            int e;
            e = $urandom_range(7);
            expect_frame(8 - e, 1'b0, 1'b0);
            put(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'(e), 1'b0);
        end
        chk_cnt("b2b_single");

        orphans(4);
        chk_cnt("orphans");

        frame(8200, 0, 1'b0, 1'b0, 0, 1'b0);
        chk_cnt("len_sat");

        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = $urandom_range(9);
            if (sel < 6)
                frame($urandom_range(1, 200), $urandom_range(7),
                      ($urandom_range(3) == 0), ($urandom_range(4) == 0), 20, 1'b0);
            else if (sel == 6) abort_sop($urandom_range(1, 10));
            else if (sel == 7) abort_dv($urandom_range(1, 10));
            else orphans($urandom_range(1, 3));
            idle($urandom_range(0, 2));
        end
        chk_cnt("random");

        for (int i = 0; i < 3; i++)
            put(1'b1, 1'b1, 1'b1, i == 0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b0;
        put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        idle(1);
        rst_n  = 1'b1;
        m_good = 0;
        m_bad  = 0;
        m_orph = 0;
        chk("midrst_vld", 32'(stat_vld), 0);
        chk_cnt("midrst");
        frame(10, 0, 1'b0, 1'b0, 0, 1'b0);
        chk_cnt("after_rst");

        orphans(2);
        frame(3, 0, 1'b1, 1'b0, 0, 1'b0);
        frame(9, 4, 1'b0, 1'b0, 0, 1'b1);
        chk_cnt("clr_on_good");

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_10g_rx_chk.md
# mac_10g_rx_chk

Receive-side frame checker that sits directly downstream of the 10G MAC bus (clock-enable, data-enable, sop/eop, empty, error signalling) and consumes every beat it carries. It checks framing per frame, measures the byte length, classifies each frame, and emits one status record per frame plus running statistics counters. It feeds the scoreboard and statistics path.

## Interface

Parameters:
- MAC_DWIDTH, 64, bus data width in bits; taken from the shared parameter.sv; multiple of 8.
- MAC_MOD_WIDTH, 3, width of empty; log2(MAC_DWIDTH/8); taken from parameter.sv.
- MIN_LEN, 64, smallest legal frame length in bytes.
- MAX_LEN, 1518, largest legal frame length in bytes.
- LEN_WIDTH, 16, width of the length accumulator and o_stat_len.
- CNT_WIDTH, 32, width of the good/bad counters.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst_n  in  1  reset; synchronous and active-low.
- i_clk_en  in  1  qualifies the cycle; when low, all bus inputs are ignored.
- i_dv  in  1  frame-active indicator from the MAC.
- i_data_en  in  1  data word valid.
- i_data  in  MAC_DWIDTH  payload; not inspected.
- i_sop  in  1  first beat of a frame.
- i_eop  in  1  last beat of a frame.
- i_empty  in  MAC_MOD_WIDTH  count of unused bytes in the eop beat.
- i_error  in  1  MAC error flag; sampled on the eop beat only.
- i_clr_cnt  in  1  synchronous clear of all counters.
- o_stat_vld  out  1  one-cycle pulse per reported frame.
- o_stat_len  out  LEN_WIDTH  byte length of the reported frame.
- o_stat_code  out  3  0 GOOD, 1 MAC_ERR, 2 RUNT, 3 OVERSIZE, 4 FRAMING.
- o_good_cnt  out  CNT_WIDTH  count of GOOD frames; wraps.
- o_bad_cnt  out  CNT_WIDTH  count of all non-GOOD frames; wraps.
- o_orphan_cnt  out  16  beats discarded outside a frame; saturates at 0xFFFF.

## Operation

- A beat is accepted when i_clk_en && i_data_en.
- FSM has two states: IDLE and IN_FRAME.
- IDLE behaviour:
  - An accepted beat with i_sop starts a frame. The accumulator loads MAC_DWIDTH/8, or MAC_DWIDTH/8 − i_empty when i_eop is also high.
  - When i_sop and i_eop are both high, the frame is a single-beat frame: it is reported immediately and the FSM stays in IDLE.
  - Otherwise the FSM goes to IN_FRAME.
  - An accepted beat without i_sop is an orphan: it is discarded and o_orphan_cnt is incremented.
- IN_FRAME behaviour:
  - Each accepted beat adds MAC_DWIDTH/8 to the accumulator.
  - On the eop beat, the beat adds MAC_DWIDTH/8 − i_empty instead; the frame is reported and the FSM goes to IDLE.
  - Abort conditions, each reported as FRAMING with the length accumulated before the offending cycle, then FSM to IDLE:
    - an accepted beat with i_sop; that beat is discarded and counted as an orphan;
    - i_clk_en && !i_dv.
- Classification priority: FRAMING > MAC_ERR (i_error on eop) > RUNT (len < MIN_LEN) > OVERSIZE (len > MAX_LEN) > GOOD.
- The accumulator saturates at 2^LEN_WIDTH−1 and never wraps.
- i_empty is ignored on non-eop beats.
- o_good_cnt increments on GOOD; o_bad_cnt increments on every other code. Both wrap.

## Timing

- Reset values: all outputs 0; FSM IDLE; accumulator 0.
- Reset taken mid-frame discards the partial frame; no status is emitted.
- o_stat_vld, o_stat_len and o_stat_code are registered. They are valid exactly one cycle after the eop or abort cycle.
- Counters update on the same edge that raises o_stat_vld.
- Throughput: one frame per cycle with back-to-back single-beat frames; no backpressure.
- i_clr_cnt in the same cycle as a counter update: the clear wins and the counter reads 0 afterwards.
- i_clk_en low freezes the FSM and accumulator. Pending status output is not delayed by it.

## Structure

- Package mac_10g_chk_pkg holds:
  - the stat_code_e enum (GOOD, MAC_ERR, RUNT, OVERSIZE, FRAMING);
  - the constant BYTES_PER_BEAT = MAC_DWIDTH/8.
- MAC_DWIDTH and MAC_MOD_WIDTH stay in parameter.sv.
- One sub-module, mac_10g_cnt: a generic counter with a WIDTH parameter, a SATURATE parameter, increment, and synchronous clear. It is instantiated for the good, bad and orphan counters.

## Test plan

- 8-beat frame, i_empty=0, no error -> one cycle after eop: o_stat_vld=1, len=64, code GOOD; o_good_cnt=1.
- Single beat with sop+eop, i_empty=3 -> len=5, code RUNT; o_bad_cnt=1.
- 24-beat frame with i_empty=2 and i_error=1 on eop -> len=190, code MAC_ERR (MAC_ERR takes priority over RUNT/OVERSIZE).
- 3 beats, then a new sop beat before any eop -> FRAMING with len=24; o_orphan_cnt=1; FSM in IDLE.
- 191-beat frame with i_empty=0 -> len=1528, code OVERSIZE. Repeat with i_clk_en toggling every other cycle -> identical result.
- Reset asserted on beat 4 of a frame, and separately i_clr_cnt coincident with a GOOD report -> in both cases no status pulse or counters read 0, and all counters read 0 afterwards.
